// File: rtl/sdfa_setup_streamer.sv
// Setup/feature streamer for sdfa_master: replays a host-written per-block
// configuration table on setup_request and feeds buffered feature words on demand.
module sdfa_setup_streamer #(
    parameter  int BLOCK_NUM  = 8,
    parameter  int ADDR_WIDTH = 3,
    parameter  int FIFO_DEPTH = 16,
    localparam int ID_WIDTH   = 3*BLOCK_NUM + 3*ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    // configuration table
    input  logic                  cfg_we,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [ID_WIDTH-1:0]   cfg_block_id,
    input  logic [ADDR_WIDTH-1:0] cfg_num_per_layer,
    input  logic [BLOCK_NUM-1:0]  cfg_read_block,
    input  logic                  cfg_clear,
    output logic                  cfg_err,
    // setup stream
    input  logic                  setup_request,
    output logic                  setup_valid,
    output logic [ID_WIDTH-1:0]   BLOCK_ID_INPUT,
    output logic [ADDR_WIDTH-1:0] BLOCK_NUM_PER_LAYER_INPUT,
    output logic [BLOCK_NUM-1:0]  READ_BLOCK_INPUT,
    output logic                  setup_done,
    // feature stream
    input  logic                  feat_push,
    input  logic [BLOCK_NUM-1:0]  feat_data,
    output logic                  feat_full,
    output logic                  feat_ovf,
    input  logic                  block_result_request,
    input  logic                  done,
    output logic [BLOCK_NUM-1:0]  feature,
    output logic                  feature_valid
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_K  = ADDR_WIDTH'(BLOCK_NUM - 1);
    localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_LOW
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_k;
    logic [BLOCK_NUM-1:0]  r_valid;

    logic [ID_WIDTH-1:0]   r_tbl_id  [BLOCK_NUM];
    logic [ADDR_WIDTH-1:0] r_tbl_npl [BLOCK_NUM];
    logic [BLOCK_NUM-1:0]  r_tbl_rb  [BLOCK_NUM];

    logic                  w_in_load;
    logic                  w_addr_ok;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_nidx;
    logic                  w_nvalid;
    logic [ID_WIDTH-1:0]   w_ent_id;
    logic [ADDR_WIDTH-1:0] w_ent_npl;
    logic [BLOCK_NUM-1:0]  w_ent_rb;

    assign w_in_load = (r_state == ST_LOAD);
    assign w_addr_ok = int'(cfg_addr) < BLOCK_NUM;
    assign w_wr      = cfg_we && !w_in_load && w_addr_ok && !cfg_clear;

    // Index of the entry presented after the next edge: 0 when starting, k+1 while loading.
    assign w_nidx    = (w_in_load && (r_k != LAST_K)) ? r_k + 1'b1 : '0;
    assign w_nvalid  = r_valid[w_nidx];
    assign w_ent_id  = w_nvalid ? r_tbl_id[w_nidx]  : '0;
    assign w_ent_npl = w_nvalid ? r_tbl_npl[w_nidx] : '0;
    assign w_ent_rb  = w_nvalid ? r_tbl_rb[w_nidx]  : '0;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_tbl_id[cfg_addr]  <= cfg_block_id;
            r_tbl_npl[cfg_addr] <= cfg_num_per_layer;
            r_tbl_rb[cfg_addr]  <= cfg_read_block;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state                   <= ST_IDLE;
            r_k                       <= '0;
            r_valid                   <= '0;
            cfg_err                   <= 1'b0;
            setup_valid               <= 1'b0;
            setup_done                <= 1'b0;
            BLOCK_ID_INPUT            <= '0;
            BLOCK_NUM_PER_LAYER_INPUT <= '0;
            READ_BLOCK_INPUT          <= '0;
        end else begin
            cfg_err    <= cfg_we && (w_in_load || !w_addr_ok);
            setup_done <= 1'b0;

            if (cfg_clear && !w_in_load) begin
                r_valid <= '0;
            end else if (w_wr) begin
                r_valid[cfg_addr] <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (setup_request) begin
                        r_state                   <= ST_LOAD;
                        r_k                       <= '0;
                        setup_valid               <= 1'b1;
                        BLOCK_ID_INPUT            <= w_ent_id;
                        BLOCK_NUM_PER_LAYER_INPUT <= w_ent_npl;
                        READ_BLOCK_INPUT          <= w_ent_rb;
                    end
                end
                ST_LOAD: begin
                    if (r_k == LAST_K) begin
                        r_state                   <= ST_WAIT_LOW;
                        setup_valid               <= 1'b0;
                        setup_done                <= 1'b1;
                        BLOCK_ID_INPUT            <= '0;
                        BLOCK_NUM_PER_LAYER_INPUT <= '0;
                        READ_BLOCK_INPUT          <= '0;
                    end else begin
                        r_k                       <= r_k + 1'b1;
                        setup_valid               <= 1'b1;
                        BLOCK_ID_INPUT            <= w_ent_id;
                        BLOCK_NUM_PER_LAYER_INPUT <= w_ent_npl;
                        READ_BLOCK_INPUT          <= w_ent_rb;
                    end
                end
                ST_WAIT_LOW: begin
                    // A request held high must drop before another load can start.
                    if (!setup_request) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    logic [BLOCK_NUM-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_stream;

    logic                 w_empty;
    logic                 w_full_now;
    logic                 w_pop;
    logic                 w_push;
    logic [CNT_W-1:0]     w_count_nxt;

    assign w_empty     = (r_count == '0);
    assign w_full_now  = (r_count == DEPTH_C);
    // done wins over an active stream, so nothing is popped in the cycle it is seen.
    assign w_pop       = r_stream && !done && !w_empty;
    assign w_push      = feat_push && (!w_full_now || w_pop);
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= feat_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_stream      <= 1'b0;
            feat_full     <= 1'b0;
            feat_ovf      <= 1'b0;
            feature       <= '0;
            feature_valid <= 1'b0;
        end else begin
            if (done) begin
                r_stream <= 1'b0;
            end else if (block_result_request) begin
                r_stream <= 1'b1;
            end

            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count   <= w_count_nxt;
            feat_full <= (w_count_nxt == DEPTH_C);

            if (feat_push && w_full_now && !w_pop) begin
                feat_ovf <= 1'b1;
            end

            feature_valid <= w_pop;
            if (w_pop) begin
                feature <= r_mem[r_rptr];
            end else if (!(r_stream && !done)) begin
                feature <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sdfa_setup_streamer.sv
// Directed bench for sdfa_setup_streamer: default 8-block instance plus a
// 12-block instance for the extended address range.
module tb_sdfa_setup_streamer;

    localparam int ID8  = 33;
    localparam int ID12 = 48;

    logic clk;
    logic rstn;

    logic            cfg_we, cfg_clear, setup_request, feat_push;
    logic [2:0]      cfg_addr, cfg_num_per_layer;
    logic [ID8-1:0]  cfg_block_id;
    logic [7:0]      cfg_read_block, feat_data;
    logic            block_result_request, done;
    logic            cfg_err, setup_valid, setup_done, feat_full, feat_ovf, feature_valid;
    logic [ID8-1:0]  BLOCK_ID_INPUT;
    logic [2:0]      BLOCK_NUM_PER_LAYER_INPUT;
    logic [7:0]      READ_BLOCK_INPUT, feature;

    logic            c12_we, c12_req;
    logic [3:0]      c12_addr, c12_npl;
    logic [ID12-1:0] c12_id;
    logic [11:0]     c12_rb;
    logic            c12_err, c12_sv, c12_sdone, c12_full, c12_ovf, c12_fv;
    logic [ID12-1:0] c12_id_o;
    logic [3:0]      c12_npl_o;
    logic [11:0]     c12_rb_o, c12_feat;

    int n_checks = 0;
    int n_err    = 0;

    logic [ID8-1:0] exp_id  [8];
    logic [2:0]     exp_npl [8];
    logic [7:0]     exp_rb  [8];

    localparam logic [ID8-1:0] ID_A = 33'b00111111_11000011_000_11000011_100_001;
    localparam logic [ID8-1:0] ID_B = 33'b01111111_01111111_001_11111111_010_010;

    sdfa_setup_streamer dut (
        .clk(clk), .rstn(rstn),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_block_id(cfg_block_id),
        .cfg_num_per_layer(cfg_num_per_layer), .cfg_read_block(cfg_read_block),
        .cfg_clear(cfg_clear), .cfg_err(cfg_err),
        .setup_request(setup_request), .setup_valid(setup_valid),
        .BLOCK_ID_INPUT(BLOCK_ID_INPUT), .BLOCK_NUM_PER_LAYER_INPUT(BLOCK_NUM_PER_LAYER_INPUT),
        .READ_BLOCK_INPUT(READ_BLOCK_INPUT), .setup_done(setup_done),
        .feat_push(feat_push), .feat_data(feat_data), .feat_full(feat_full), .feat_ovf(feat_ovf),
        .block_result_request(block_result_request), .done(done),
        .feature(feature), .feature_valid(feature_valid)
    );

    sdfa_setup_streamer #(.BLOCK_NUM(12), .ADDR_WIDTH(4), .FIFO_DEPTH(16)) dut12 (
        .clk(clk), .rstn(rstn),
        .cfg_we(c12_we), .cfg_addr(c12_addr), .cfg_block_id(c12_id),
        .cfg_num_per_layer(c12_npl), .cfg_read_block(c12_rb),
        .cfg_clear(1'b0), .cfg_err(c12_err),
        .setup_request(c12_req), .setup_valid(c12_sv),
        .BLOCK_ID_INPUT(c12_id_o), .BLOCK_NUM_PER_LAYER_INPUT(c12_npl_o),
        .READ_BLOCK_INPUT(c12_rb_o), .setup_done(c12_sdone),
        .feat_push(1'b0), .feat_data(12'h000), .feat_full(c12_full), .feat_ovf(c12_ovf),
        .block_result_request(1'b0), .done(1'b0),
        .feature(c12_feat), .feature_valid(c12_fv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [ID8-1:0] id,
                      input logic [2:0] npl, input logic [7:0] rb);
        cfg_we = 1'b1; cfg_addr = a; cfg_block_id = id;
        cfg_num_per_layer = npl; cfg_read_block = rb;
        step();
        cfg_we = 1'b0;
    endtask

    // Raise setup_request and check the full stream; entries with mask[k]=0 must read zero.
    task automatic run_stream(input logic [7:0] mask, input bit inj, input int hold);
        int extra;
        setup_request = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            chk("setup_valid", 64'(setup_valid), 64'(1));
            chk("block_id", 64'(BLOCK_ID_INPUT), mask[k] ? 64'(exp_id[k]) : 64'(0));
            chk("num_per_layer", 64'(BLOCK_NUM_PER_LAYER_INPUT), mask[k] ? 64'(exp_npl[k]) : 64'(0));
            chk("read_block", 64'(READ_BLOCK_INPUT), mask[k] ? 64'(exp_rb[k]) : 64'(0));
            chk("setup_done_in_load", 64'(setup_done), 64'(0));
            if (inj && k == 4) chk("cfg_err_load", 64'(cfg_err), 64'(1));
            if (inj && k == 5) chk("cfg_err_pulse", 64'(cfg_err), 64'(0));
            cfg_we = inj && (k == 3);
            cfg_addr = 3'd6; cfg_block_id = '1; cfg_num_per_layer = 3'd7; cfg_read_block = 8'hFF;
            step();
        end
        cfg_we = 1'b0;
        chk("setup_valid_end", 64'(setup_valid), 64'(0));
        chk("setup_done", 64'(setup_done), 64'(1));
        chk("block_id_end", 64'(BLOCK_ID_INPUT), 64'(0));
        chk("read_block_end", 64'(READ_BLOCK_INPUT), 64'(0));
        extra = 0;
        for (int c = 0; c < hold; c++) begin
            step();
            if (setup_valid || setup_done) extra++;
        end
        chk("held_request_extra", 64'(extra), 64'(0));
        setup_request = 1'b0;
        step();
        step();
    endtask

    task automatic wait_fv(input string tag);
        int n;
        n = 0;
        while (!feature_valid && n < 8) begin
            step();
            n++;
        end
        chk(tag, 64'(feature_valid), 64'(1));
    endtask

    initial begin
        logic [7:0] got[$];
        logic [7:0] exp3 [3];

        exp3[0] = 8'hA5; exp3[1] = 8'h3C; exp3[2] = 8'h81;
        for (int i = 0; i < 8; i++) begin
            exp_id[i] = '0; exp_npl[i] = '0; exp_rb[i] = '0;
        end
        for (int i = 0; i < 4; i++) exp_id[i] = ID_A;
        exp_npl[0] = 3'd4; exp_npl[1] = 3'd2; exp_npl[2] = 3'd1; exp_npl[3] = 3'd0;
        exp_id[4] = ID_B; exp_npl[4] = 3'd3; exp_rb[4] = 8'h03;
        exp_id[5] = ID_B; exp_npl[5] = 3'd5; exp_rb[5] = 8'h03;

        rstn = 1'b0;
        cfg_we = 0; cfg_clear = 0; cfg_addr = 0; cfg_block_id = 0; cfg_num_per_layer = 0;
        cfg_read_block = 0; setup_request = 0; feat_push = 0; feat_data = 0;
        block_result_request = 0; done = 0;
        c12_we = 0; c12_req = 0; c12_addr = 0; c12_id = 0; c12_npl = 0; c12_rb = 0;

        #3;
        chk("rst_setup_valid", 64'(setup_valid), 64'(0));
        chk("rst_setup_done", 64'(setup_done), 64'(0));
        chk("rst_cfg_err", 64'(cfg_err), 64'(0));
        chk("rst_block_id", 64'(BLOCK_ID_INPUT), 64'(0));
        chk("rst_feat_full", 64'(feat_full), 64'(0));
        chk("rst_feat_ovf", 64'(feat_ovf), 64'(0));
        chk("rst_feature_valid", 64'(feature_valid), 64'(0));
        chk("rst_feature", 64'(feature), 64'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step();

        // 12-block instance: address 8 is in range, 12 is not
        c12_we = 1'b1; c12_addr = 4'd8; c12_id = 48'h0000_ABCD_1234; c12_npl = 4'd9; c12_rb = 12'hF0F;
        step();
        chk("c12_err_addr8", 64'(c12_err), 64'(0));
        c12_addr = 4'd12;
        step();
        c12_we = 1'b0;
        chk("c12_err_addr12", 64'(c12_err), 64'(1));
        c12_req = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            if (k == 0) chk("c12_entry0_id", 64'(c12_id_o), 64'(0));
            if (k == 8) begin
                chk("c12_entry8_valid", 64'(c12_sv), 64'(1));
                chk("c12_entry8_id", 64'(c12_id_o), 64'h0000_ABCD_1234);
                chk("c12_entry8_npl", 64'(c12_npl_o), 64'(9));
                chk("c12_entry8_rb", 64'(c12_rb_o), 64'hF0F);
            end
            step();
        end
        chk("c12_setup_done", 64'(c12_sdone), 64'(1));
        c12_req = 1'b0;

        for (int i = 0; i < 6; i++) wr(3'(i), exp_id[i], exp_npl[i], exp_rb[i]);
        chk("cfg_err_idle_write", 64'(cfg_err), 64'(0));

        run_stream(8'h3F, 1'b1, 31);
        run_stream(8'h3F, 1'b0, 0);

        cfg_clear = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd2; cfg_block_id = ID_A;
        cfg_num_per_layer = 3'd1; cfg_read_block = 8'h00;
        step();
        cfg_clear = 1'b0; cfg_we = 1'b0;
        chk("cfg_err_clear", 64'(cfg_err), 64'(0));
        wr(3'd5, exp_id[5], exp_npl[5], exp_rb[5]);
        run_stream(8'h20, 1'b0, 0);

        setup_request = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        chk("pre_reset_valid", 64'(setup_valid), 64'(1));
        #2;
        rstn = 1'b0;
        #1;
        chk("reset_mid_load_valid", 64'(setup_valid), 64'(0));
        chk("reset_mid_load_id", 64'(BLOCK_ID_INPUT), 64'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        setup_request = 1'b0;
        step();
        run_stream(8'h00, 1'b0, 0);

        // feature path
        for (int i = 0; i < 6; i++) begin
            feat_push = 1'b1;
            feat_data = (i == 0) ? 8'hFF : 8'h00;
            step();
        end
        feat_push = 1'b0;
        block_result_request = 1'b1;
        wait_fv("feat_first_valid");
        for (int i = 0; i < 6; i++) begin
            chk("feat_burst_valid", 64'(feature_valid), 64'(1));
            chk("feat_burst_data", 64'(feature), (i == 0) ? 64'hFF : 64'h00);
            step();
        end
        chk("feat_burst_end", 64'(feature_valid), 64'(0));

        for (int c = 0; c < 10; c++) begin
            feat_push = (c < 3);
            feat_data = (c < 3) ? exp3[c] : 8'h00;
            step();
            if (feature_valid) got.push_back(feature);
        end
        feat_push = 1'b0;
        chk("feat_resume_count", 64'(got.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) chk("feat_resume_data", 64'(got[i]), 64'(exp3[i]));
        end
        chk("feat_hold_last", 64'(feature), 64'h81);
        chk("feat_hold_valid", 64'(feature_valid), 64'(0));

        feat_push = 1'b1; feat_data = 8'h5A;
        step();
        feat_push = 1'b0; done = 1'b1; block_result_request = 1'b0;
        step();
        chk("done_valid", 64'(feature_valid), 64'(0));
        chk("done_feature_zero", 64'(feature), 64'(0));
        done = 1'b0;
        step();
        step();
        chk("idle_valid", 64'(feature_valid), 64'(0));
        block_result_request = 1'b1;
        wait_fv("retained_valid");
        chk("retained_word", 64'(feature), 64'h5A);
        done = 1'b1; block_result_request = 1'b0;
        step();
        done = 1'b0;
        step();

        for (int i = 0; i < 17; i++) begin
            feat_push = 1'b1;
            feat_data = 8'h10 + 8'(i);
            step();
            if (i == 14) chk("full_after_15", 64'(feat_full), 64'(0));
            if (i == 15) begin
                chk("full_after_16", 64'(feat_full), 64'(1));
                chk("ovf_after_16", 64'(feat_ovf), 64'(0));
            end
            if (i == 16) chk("ovf_after_17", 64'(feat_ovf), 64'(1));
        end
        feat_push = 1'b0;
        block_result_request = 1'b1;
        wait_fv("full_drain_valid");
        for (int i = 0; i < 16; i++) begin
            chk("full_drain_valid_i", 64'(feature_valid), 64'(1));
            chk("full_drain_data", 64'(feature), 64'(8'h10 + 8'(i)));
            step();
        end
        chk("full_drain_end", 64'(feature_valid), 64'(0));
        chk("full_cleared", 64'(feat_full), 64'(0));
        chk("ovf_sticky", 64'(feat_ovf), 64'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
